ssd_scan_mux: RTL and testbench

Parametrised time-multiplexed seven-segment display driver, the successor to the fixed 4-digit scanner. It scans NUM_DIGITS hex digits with a programmable dwell time per digit and blanks the anodes between digits to suppress ghosting. It decodes hex to active-low segments, drives decimal points, supports per-digit enables and leading-zero suppression, and samples its inputs once per frame so each frame shows a single coherent value. It sits between the BCD/hex value logic and the board anode/cathode pins.

---
 rtl/ssd_scan_mux.sv | 200 ++++++++++++++++++++
 tb/tb_ssd_scan_mux.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_mux.sv
// ---------------------------------------------------------------------------
// ssd_scan_mux
//
// Time-multiplexed seven-segment display driver. Scans NUM_DIGITS hex digits.
// Each digit slot lasts CYCLES_PER_DIGIT clocks. The first BLANK_CYCLES of
// every slot keep all anodes off to suppress ghosting. The driver decodes hex
// to active-low segments and drives the decimal points. It supports per-digit
// enables and leading-zero suppression. All inputs are snapshotted once per
// frame, so each frame shows a single coherent value.
//
// Ports:
//   clock         rising-edge system clock
//   reset         synchronous, active-high reset
//   digits_i      packed hex digits, digit k in [4k+3:4k], digit 0 rightmost
//   dp_i          decimal-point request per digit, active-high
//   digit_en_i    per-digit enable, 0 keeps that anode dark for its slot
//   lz_blank_i    1 = suppress leading zeros
//   digit_select  anode drive, active-low (one-cold or all ones)
//   segments      cathodes {g,f,e,d,c,b,a}, active-low
//   dp_out        decimal-point cathode, active-low
//   frame_tick    one-cycle pulse on the last cycle of each frame
// ---------------------------------------------------------------------------
module ssd_scan_mux #(
    parameter int NUM_DIGITS       = 4,
    parameter int CYCLES_PER_DIGIT = 100000,
    parameter int BLANK_CYCLES     = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    input  logic                    lz_blank_i,
    output logic [NUM_DIGITS-1:0]   digit_select,
    output logic [6:0]              segments,
    output logic                    dp_out,
    output logic                    frame_tick
);

    localparam int CW = (CYCLES_PER_DIGIT > 1) ? $clog2(CYCLES_PER_DIGIT) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES_PER_DIGIT - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    // Hex to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode_hex(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Bit k set when digit k (k > 0) and every digit above it are zero.
    // Enables are deliberately ignored: the test is on values only.
    function automatic logic [NUM_DIGITS-1:0] lead_zeros(input logic [4*NUM_DIGITS-1:0] d);
        logic [NUM_DIGITS-1:0] m;
        logic                  all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero && (d[4*k +: 4] == 4'h0);
            m[k]     = all_zero && (k != 0);
        end
        return m;
    endfunction

    // Scan state and per-frame snapshot (stage p0).
    logic [CW-1:0]           cnt_p0;
    logic [IW-1:0]           idx_p0;
    logic [4*NUM_DIGITS-1:0] snap_digits_p0;
    logic [NUM_DIGITS-1:0]   snap_dp_p0;
    logic [NUM_DIGITS-1:0]   snap_en_p0;
    logic                    snap_lz_p0;

    // Next-state values. Outputs are derived from these, so the registered
    // outputs line up with the cycle the state registers describe.
    logic [CW-1:0]           cnt_nxt;
    logic [IW-1:0]           idx_nxt;
    logic [4*NUM_DIGITS-1:0] snap_digits_nxt;
    logic [NUM_DIGITS-1:0]   snap_dp_nxt;
    logic [NUM_DIGITS-1:0]   snap_en_nxt;
    logic                    snap_lz_nxt;
    logic                    slot_wrap;
    logic                    frame_end;
    logic                    in_blank;

    logic [3:0]              cur_digit;
    logic                    cur_dp;
    logic                    cur_en;
    logic                    cur_lead;
    logic [NUM_DIGITS-1:0]   lead_mask;

    logic [NUM_DIGITS-1:0]   sel_nxt;
    logic [6:0]              seg_nxt;
    logic                    dp_nxt;
    logic                    tick_nxt;

    always_comb begin
        slot_wrap = (cnt_p0 == CNT_MAX);
        frame_end = slot_wrap && (idx_p0 == IDX_MAX);

        cnt_nxt = slot_wrap ? '0 : cnt_p0 + CW'(1);
        idx_nxt = idx_p0;
        if (slot_wrap) begin
            idx_nxt = (idx_p0 == IDX_MAX) ? '0 : idx_p0 + IW'(1);
        end

        // Inputs only take effect at the frame boundary.
        snap_digits_nxt = frame_end ? digits_i   : snap_digits_p0;
        snap_dp_nxt     = frame_end ? dp_i       : snap_dp_p0;
        snap_en_nxt     = frame_end ? digit_en_i : snap_en_p0;
        snap_lz_nxt     = frame_end ? lz_blank_i : snap_lz_p0;
    end

    // With no blank window the anode hands over directly on the slot edge.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (cnt_nxt < CW'(BLANK_CYCLES));
        end
    endgenerate

    always_comb begin
        lead_mask = lead_zeros(snap_digits_nxt);
        cur_digit = 4'h0;
        cur_dp    = 1'b0;
        cur_en    = 1'b0;
        cur_lead  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_nxt == IW'(k)) begin
                cur_digit = snap_digits_nxt[4*k +: 4];
                cur_dp    = snap_dp_nxt[k];
                cur_en    = snap_en_nxt[k];
                cur_lead  = lead_mask[k];
            end
        end

        sel_nxt  = '1;
        seg_nxt  = 7'h7F;
        dp_nxt   = 1'b1;
        tick_nxt = (cnt_nxt == CNT_MAX) && (idx_nxt == IDX_MAX);

        // A disabled digit stays dark for the whole slot.
        if (!in_blank && cur_en) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_nxt == IW'(k)) begin
                    sel_nxt[k] = 1'b0;
                end
            end
            // A suppressed leading zero keeps its anode and decimal point.
            seg_nxt = (snap_lz_nxt && cur_lead) ? 7'h7F : decode_hex(cur_digit);
            dp_nxt  = ~cur_dp;
        end
    end

    // Register stage: scan state, snapshot and outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_p0         <= '0;
            idx_p0         <= '0;
            snap_digits_p0 <= digits_i;
            snap_dp_p0     <= dp_i;
            snap_en_p0     <= digit_en_i;
            snap_lz_p0     <= lz_blank_i;
            digit_select   <= '1;
            segments       <= 7'h7F;
            dp_out         <= 1'b1;
            frame_tick     <= 1'b0;
        end else begin
            cnt_p0         <= cnt_nxt;
            idx_p0         <= idx_nxt;
            snap_digits_p0 <= snap_digits_nxt;
            snap_dp_p0     <= snap_dp_nxt;
            snap_en_p0     <= snap_en_nxt;
            snap_lz_p0     <= snap_lz_nxt;
            digit_select   <= sel_nxt;
            segments       <= seg_nxt;
            dp_out         <= dp_nxt;
            frame_tick     <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_ssd_scan_mux.sv
module tb_ssd_scan_mux;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        lz;
        logic [15:0] sel;   // steady anode pattern, slot k in [4k+3:4k]
        logic [27:0] seg;   // steady segments, slot k in [7k+6:7k]
        logic [3:0]  dpo;   // steady dp_out, slot k in bit k
    } vec_t;

    typedef struct {
        bit         big;
        int         t;
        logic [7:0] sel;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] digits_i;
    logic [3:0]  dp_i;
    logic [3:0]  en_i;
    logic        lz_i;
    logic [3:0]  sel4;
    logic [6:0]  seg4;
    logic        dp4;
    logic        tick4;

    logic [31:0] digits8;
    logic [7:0]  dp8_i;
    logic [7:0]  en8_i;
    logic        lz8_i;
    logic [7:0]  sel8;
    logic [6:0]  seg8;
    logic        dp8;
    logic        tick8;

    always #5 clock = ~clock;

    ssd_scan_mux #(.NUM_DIGITS(4), .CYCLES_PER_DIGIT(8), .BLANK_CYCLES(2)) dut4 (
        .clock(clock), .reset(reset), .digits_i(digits_i), .dp_i(dp_i),
        .digit_en_i(en_i), .lz_blank_i(lz_i), .digit_select(sel4),
        .segments(seg4), .dp_out(dp4), .frame_tick(tick4)
    );

    ssd_scan_mux #(.NUM_DIGITS(8), .CYCLES_PER_DIGIT(8), .BLANK_CYCLES(0)) dut8 (
        .clock(clock), .reset(reset), .digits_i(digits8), .dp_i(dp8_i),
        .digit_en_i(en8_i), .lz_blank_i(lz8_i), .digit_select(sel8),
        .segments(seg8), .dp_out(dp8), .frame_tick(tick8)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t vecs[8];
    vec_t v_abcd;
    logic [6:0] dec8[8];

    // Expected outputs of the 4-digit unit at cycle t after reset release.
    function automatic exp_t exp4(vec_t v, int t);
        exp_t e;
        int   s;
        int   c;
        s      = (t % 32) / 8;
        c      = t % 8;
        e.big  = 1'b0;
        e.t    = t;
        e.sel  = 8'hFF;
        e.seg  = 7'h7F;
        e.dp   = 1'b1;
        e.tick = (t % 32 == 31);
        if (c >= 2) begin
            e.sel = {4'hF, v.sel[s*4 +: 4]};
            e.seg = v.seg[s*7 +: 7];
            e.dp  = v.dpo[s];
        end
        return e;
    endfunction

    // Expected outputs of the 8-digit, no-blank unit showing 76543210.
    function automatic exp_t exp8(int t);
        exp_t e;
        int   s;
        s      = (t % 64) / 8;
        e.big  = 1'b1;
        e.t    = t;
        e.sel  = 8'hFF;
        e.seg  = 7'h7F;
        e.dp   = 1'b1;
        e.tick = 1'b0;
        if (t != 0) begin
            e.sel  = ~(8'd1 << s);
            e.seg  = dec8[s];
            e.tick = (t % 64 == 63);
        end
        return e;
    endfunction

    task automatic check(input string name);
        exp_t       e;
        logic [7:0] a_sel;
        logic [6:0] a_seg;
        logic       a_dp;
        logic       a_tick;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        if (e.big) begin
            a_sel = sel8; a_seg = seg8; a_dp = dp8; a_tick = tick8;
        end else begin
            a_sel = {4'hF, sel4}; a_seg = seg4; a_dp = dp4; a_tick = tick4;
        end
        if (a_sel !== e.sel || a_seg !== e.seg || a_dp !== e.dp || a_tick !== e.tick) begin
            n_err++;
            $display("FAIL %s t=%0d: got sel=%b seg=%b dp=%b tick=%b, want sel=%b seg=%b dp=%b tick=%b",
                     name, e.t, a_sel, a_seg, a_dp, a_tick, e.sel, e.seg, e.dp, e.tick);
        end
    endtask

    task automatic step(input exp_t e, input string name);
        sb.push_back(e);
        @(posedge clock);
        #1;
        check(name);
    endtask

    // Hold reset for n edges; outputs after the last one are cycle 0.
    task automatic do_reset(input int n, input exp_t e, input string name);
        reset = 1'b1;
        for (int i = 0; i < n - 1; i++) @(posedge clock);
        sb.push_back(e);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check(name);
    endtask

    task automatic run4(input vec_t v, input int t0, input int t1, input string name);
        for (int t = t0; t <= t1; t++) step(exp4(v, t), name);
    endtask

    task automatic apply(input vec_t v);
        digits_i = v.digits;
        dp_i     = v.dp;
        en_i     = v.en;
        lz_i     = v.lz;
    endtask

    initial begin
        dec8[0] = 7'b1000000; dec8[1] = 7'b1111001; dec8[2] = 7'b0100100; dec8[3] = 7'b0110000;
        dec8[4] = 7'b0011001; dec8[5] = 7'b0010010; dec8[6] = 7'b0000010; dec8[7] = 7'b1111000;

        //          digits    dp     en     lz    sel        seg {slot3,slot2,slot1,slot0}                            dpo
        vecs[0] = '{16'h1234, 4'h0, 4'hF, 1'b0, 16'h7BDE, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'hF};
        vecs[1] = '{16'h0070, 4'h0, 4'hF, 1'b1, 16'h7BDE, {7'h7F,      7'h7F,      7'b1111000, 7'b1000000}, 4'hF};
        vecs[2] = '{16'h0000, 4'h0, 4'hF, 1'b1, 16'h7BDE, {7'h7F,      7'h7F,      7'h7F,      7'b1000000}, 4'hF};
        vecs[3] = '{16'h1234, 4'h2, 4'hA, 1'b0, 16'h7FDF, {7'b1111001, 7'h7F,      7'b0110000, 7'h7F},      4'hD};
        vecs[4] = '{16'h8E0F, 4'hF, 4'hF, 1'b1, 16'h7BDE, {7'b0000000, 7'b0000110, 7'b1000000, 7'b0001110}, 4'h0};
        vecs[5] = '{16'hBD69, 4'h0, 4'hF, 1'b0, 16'h7BDE, {7'b0000011, 7'b0100001, 7'b0000010, 7'b0010000}, 4'hF};
        vecs[6] = '{16'h57C0, 4'h0, 4'hF, 1'b1, 16'h7BDE, {7'b0010010, 7'b1111000, 7'b1000110, 7'b1000000}, 4'hF};
        vecs[7] = '{16'h0003, 4'h8, 4'hF, 1'b1, 16'h7BDE, {7'h7F,      7'h7F,      7'h7F,      7'b0110000}, 4'h7};
        v_abcd  = '{16'hABCD, 4'h0, 4'hF, 1'b0, 16'h7BDE, {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}, 4'hF};

        reset   = 1'b1;
        digits8 = 32'h76543210;
        dp8_i   = 8'h00;
        en8_i   = 8'hFF;
        lz8_i   = 1'b0;
        apply(vecs[0]);

        // One full frame per table vector.
        for (int i = 0; i < 8; i++) begin
            apply(vecs[i]);
            do_reset(3, exp4(vecs[i], 0), $sformatf("vec%0d_reset", i));
            run4(vecs[i], 1, 31, $sformatf("vec%0d", i));
        end

        // Input change mid-frame shows only from the next frame.
        apply(vecs[0]);
        do_reset(1, exp4(vecs[0], 0), "snap_reset");
        run4(vecs[0], 1, 12, "snap_f0");
        digits_i = 16'hABCD;
        run4(vecs[0], 13, 31, "snap_f0");
        run4(v_abcd, 32, 63, "snap_f1");

        // Reset pulse mid slot 2 aborts the frame; no tick at the old cycle 31.
        apply(vecs[0]);
        do_reset(1, exp4(vecs[0], 0), "abort_reset");
        run4(vecs[0], 1, 20, "abort_pre");
        do_reset(1, exp4(vecs[0], 0), "abort_pulse");
        run4(vecs[0], 1, 31, "abort_post");

        // 8 digits, no blank window: anode walks with no all-ones gap.
        do_reset(1, exp8(0), "wide_reset");
        for (int t = 1; t < 128; t++) step(exp8(t), "wide");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
